v10_filter_event_ctrl: RTL

Sequencing controller for the trapezoidal shaping filter. It holds the filter in reset while disabled and lets the delay line settle after enabling. It then arms on a threshold crossing of the filter output and searches a fixed window for the pulse peak. Each event (peak, timestamp, pile-up flag) is handed downstream on a valid/ready interface, followed by a dead time before re-arming.

---
 rtl/v10_filter_event_ctrl_pkg.sv | 26 ++
 rtl/v10_ctrl_timer.sv | 29 ++
 rtl/v10_filter_event_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/v10_filter_event_ctrl_pkg.sv
// Shared filter parameters, default controller widths and the event FSM state type.
package v10_filter_event_ctrl_pkg;

  localparam int SIZE_ADC_DATA = 14;
  localparam int M_length      = 9;

  // Trapezoidal filter output grows by M_length bits plus one sign bit.
  localparam int DEF_DATA_W = SIZE_ADC_DATA + M_length + 1;
  localparam int DEF_TS_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ARMED  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_REPORT = 3'd4,
    ST_DEAD   = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/v10_ctrl_timer.sv
// Loadable down-counter shared by the settle, search-window and dead-time phases.
// done is high while the count is at its last cycle (1) or exhausted (0), so a
// load of N lets the owning state advance on the N-th following edge.
module v10_ctrl_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/v10_filter_event_ctrl.sv
// Event controller for the trapezoidal shaping filter: settle, arm on threshold
// crossing, search a fixed window for the peak, report on valid/ready, dead time.
//
// state  | meaning
// IDLE   | filter held in reset, waiting for enable
// SETTLE | filter running, delay line filling; data ignored
// ARMED  | waiting for a threshold crossing
// SEARCH | tracking the peak inside the window
// REPORT | event presented downstream, waiting for ready
// DEAD   | hold-off after accept before re-arming
module v10_filter_event_ctrl
  import v10_filter_event_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int PEAK_WIN   = 16,
  parameter int DEAD_TIME  = 32,
  parameter int SETTLE_CYC = 40,
  parameter int DROP_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     flt_reset_n,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_peak,
  output logic [TS_W-1:0]          evt_ts,
  output logic                     evt_pileup,
  output logic                     busy,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int TMR_W = $clog2(max3(SETTLE_CYC, DEAD_TIME, PEAK_WIN) + 1);

  state_t state, next_state;

  logic [TS_W-1:0]          ts_cnt;
  logic                     above, above_now, crossing;
  logic                     tmr_load, tmr_done;
  logic [TMR_W-1:0]         tmr_val;
  logic signed [DATA_W-1:0] peak, cand_peak;
  logic [TS_W-1:0]          peak_ts, cand_ts;
  logic                     pileup, cand_pile;
  logic                     evt_load;

  assign above_now = (filt_data > threshold);
  assign crossing  = !above && above_now;

  v10_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_val),
    .done       (tmr_done)
  );

  // Free-running timestamp and registered above-threshold flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      above  <= 1'b1;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      above  <= above_now;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state, timer loads and event-load strobe.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    evt_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(SETTLE_CYC);
        end
      end
      ST_SETTLE: begin
        if (!enable)       next_state = ST_IDLE;
        else if (tmr_done) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (crossing) begin
          if (PEAK_WIN == 1) begin
            next_state = ST_REPORT;
            evt_load   = 1'b1;
          end else begin
            next_state = ST_SEARCH;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(PEAK_WIN - 1);
          end
        end
      end
      ST_SEARCH: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (tmr_done) begin
          next_state = ST_REPORT;
          evt_load   = 1'b1;
        end
      end
      ST_REPORT: begin
        // A disable during the handshake still lets the event drain.
        if (evt_valid && evt_ready) begin
          if (!enable) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_DEAD;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(DEAD_TIME);
          end
        end
      end
      ST_DEAD: begin
        if (!enable)       next_state = ST_IDLE;
        else if (tmr_done) next_state = ST_ARMED;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Peak candidate including the current sample; ties keep the earlier one.
  always_comb begin
    cand_peak = peak;
    cand_ts   = peak_ts;
    cand_pile = pileup;
    if (state == ST_ARMED) begin
      cand_peak = filt_data;
      cand_ts   = ts_cnt;
      cand_pile = 1'b0;
    end else begin
      if (filt_data > peak) begin
        cand_peak = filt_data;
        cand_ts   = ts_cnt;
      end
      if (crossing) cand_pile = 1'b1;
    end
  end

  // Window tracking registers, updated while arming or searching.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak    <= '0;
      peak_ts <= '0;
      pileup  <= 1'b0;
    end else if (state == ST_ARMED || state == ST_SEARCH) begin
      peak    <= cand_peak;
      peak_ts <= cand_ts;
      pileup  <= cand_pile;
    end
  end

  // Event output registers and valid/ready handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid  <= 1'b0;
      evt_peak   <= '0;
      evt_ts     <= '0;
      evt_pileup <= 1'b0;
    end else if (evt_load) begin
      evt_valid  <= 1'b1;
      evt_peak   <= cand_peak;
      evt_ts     <= cand_ts;
      evt_pileup <= cand_pile;
    end else if (evt_valid && evt_ready) begin
      evt_valid  <= 1'b0;
    end
  end

  // Saturating count of crossings that arrive while an event is pending or in dead time.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if ((state == ST_REPORT || state == ST_DEAD) && crossing && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_reset_n <= 1'b0;
      busy        <= 1'b0;
    end else begin
      flt_reset_n <= (next_state != ST_IDLE);
      busy        <= (next_state == ST_SETTLE) || (next_state == ST_SEARCH) ||
                     (next_state == ST_REPORT) || (next_state == ST_DEAD);
    end
  end

endmodule
